median_sort_pipe: RTL and testbench

- Parametrised, pipelined rank-order filter for the image-processing path.
- Accepts one window of N pixels per beat and sorts it with an odd-even transposition network of compare-exchange nodes, one register stage per network layer.
- Outputs the full ascending sorted vector plus one selected rank (median, min or max) under a valid/ready handshake with backpressure.
- Successor to the single combinational compare-exchange node: generalised in width, window size and output mode, and adds pipelining and flow control.

---
 rtl/median_sort_pipe.sv | 123 ++++++++++++
 tb/tb_median_sort_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_sort_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : median_sort_pipe                                              |
// | Purpose  : Pipelined rank-order filter. Sorts an N-element window with   |
// |            an odd-even transposition network, one register stage per     |
// |            layer, and presents the sorted vector plus a selected rank.   |
// | Ports    : clk        - system clock, rising edge                         |
// |            rst        - asynchronous active-high reset                    |
// |            in_valid   - input beat valid                                  |
// |            in_ready   - block accepts a beat this cycle                   |
// |            in_data    - window, element i at [i*DATA_WIDTH +: DATA_WIDTH] |
// |            in_mode    - 0/3 median, 1 min, 2 max (sampled per beat)       |
// |            out_valid  - output beat valid                                 |
// |            out_ready  - downstream accepts the output beat                |
// |            out_data   - selected rank of the beat                         |
// |            out_sorted - ascending sorted window, element 0 = min          |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module median_sort_pipe #(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 9,
   parameter bit SORTED_EN  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N*DATA_WIDTH-1:0] in_data,
   input  logic [1:0]              in_mode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [N*DATA_WIDTH-1:0] out_sorted
);

   localparam int c_W   = N * DATA_WIDTH;
   localparam int c_MID = (N - 1) / 2;

   logic                  advance;
   logic [c_W-1:0]        data_d  [N];
   logic [c_W-1:0]        data_q  [N];
   logic [1:0]            mode_d  [N];
   logic [1:0]            mode_q  [N];
   logic [N-1:0]          valid_d;
   logic [N-1:0]          valid_q;
   logic [c_W-1:0]        layer_cur;
   logic [c_W-1:0]        layer_nxt;
   logic [DATA_WIDTH-1:0] elem_lo;
   logic [DATA_WIDTH-1:0] elem_hi;

   // The whole pipeline moves as one: it only stalls when the last stage
   // holds a beat that downstream has not taken.
   assign advance  = !valid_q[N-1] | out_ready;
   assign in_ready = advance;

   // Compare-exchange layers. Layer k pairs (j, j+1) starting at j = k%2.
   // Strict compare, so equal values never swap.
   always_comb begin
      layer_cur = '0;
      layer_nxt = '0;
      elem_lo   = '0;
      elem_hi   = '0;
      for (int k = 0; k < N; k++) begin
         layer_cur = (k == 0) ? in_data : data_q[k-1];
         layer_nxt = layer_cur;
         for (int j = k % 2; j < N - 1; j += 2) begin
            elem_lo = layer_cur[j*DATA_WIDTH +: DATA_WIDTH];
            elem_hi = layer_cur[(j+1)*DATA_WIDTH +: DATA_WIDTH];
            if (elem_lo > elem_hi) begin
               layer_nxt[j*DATA_WIDTH +: DATA_WIDTH]     = elem_hi;
               layer_nxt[(j+1)*DATA_WIDTH +: DATA_WIDTH] = elem_lo;
            end
         end
         data_d[k] = layer_nxt;
      end
   end

   // Mode and valid ride alongside the data; bubbles are not collapsed.
   always_comb begin
      mode_d[0] = in_mode;
      for (int k = 1; k < N; k++) begin
         mode_d[k] = mode_q[k-1];
      end
      valid_d = {valid_q[N-2:0], in_valid};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            data_q[k] <= '0;
            mode_q[k] <= '0;
         end
         valid_q <= '0;
      end else if (advance) begin
         for (int k = 0; k < N; k++) begin
            data_q[k] <= data_d[k];
            mode_q[k] <= mode_d[k];
         end
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q[N-1];

   // Rank select from the final (fully sorted) stage.
   always_comb begin
      case (mode_q[N-1])
         2'd1:    out_data = data_q[N-1][0 +: DATA_WIDTH];
         2'd2:    out_data = data_q[N-1][(N-1)*DATA_WIDTH +: DATA_WIDTH];
         default: out_data = data_q[N-1][c_MID*DATA_WIDTH +: DATA_WIDTH];
      endcase
   end

   generate
      if (SORTED_EN) begin : g_sorted_on
         assign out_sorted = data_q[N-1];
      end else begin : g_sorted_off
         assign out_sorted = '0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_median_sort_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_median_sort_pipe                                           |
// | Purpose  : Self-checking bench for median_sort_pipe with a queue-based   |
// |            reference model (software sort + rank select + timing).       |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_median_sort_pipe;

   localparam int DW  = 8;
   localparam int N   = 9;
   localparam int W   = N * DW;
   localparam int MID = (N - 1) / 2;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [1:0]    in_mode;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [W-1:0]  out_sorted;

   median_sort_pipe #(
      .DATA_WIDTH (DW),
      .N          (N),
      .SORTED_EN  (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_mode    (in_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sorted (out_sorted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] ref_sort(input logic [W-1:0] win);
      int v[N];
      int t;
      logic [W-1:0] r;
      for (int i = 0; i < N; i++) v[i] = int'(win[i*DW +: DW]);
      for (int i = 1; i < N; i++) begin
         t = v[i];
         for (int j = i - 1; j >= 0; j--) begin
            if (v[j] > t) begin
               v[j+1] = v[j];
               v[j]   = t;
            end
         end
      end
      r = '0;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = v[i][DW-1:0];
      return r;
   endfunction

   function automatic logic [DW-1:0] ref_sel(input logic [W-1:0] srt, input logic [1:0] mode);
      if (mode == 2'd1) return srt[0 +: DW];
      if (mode == 2'd2) return srt[(N-1)*DW +: DW];
      return srt[MID*DW +: DW];
   endfunction

   function automatic logic [W-1:0] pack(input int a[N]);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = a[i][DW-1:0];
      return r;
   endfunction

   function automatic logic [W-1:0] rand_win();
      logic [W-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
      return r;
   endfunction

   typedef struct {
      logic [W-1:0]  srt;
      logic [DW-1:0] sel;
      int            acc_cyc;
      int            acc_stall;
   } exp_t;

   exp_t sb[$];

   // ---------------- monitor / scoreboard ----------------
   int            cyc       = 0;
   int            stall_cnt = 0;
   int            n_out     = 0;
   int            run_len   = 0;
   int            max_run   = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data  = '0;
   logic [W-1:0]  prev_sorted = '0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
         prev_stall = 1'b0;
         run_len    = 0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", W'(out_valid), W'(1));
            check("hold_data", W'(out_data), W'(prev_data));
            check("hold_sorted", out_sorted, prev_sorted);
         end
         if (out_valid && !out_ready) check("in_ready_stall", W'(in_ready), W'(0));
         else                         check("in_ready_free", W'(in_ready), W'(1));
         if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("FAIL extra_beat: got output %0h, expected no beat", out_data);
            end else begin
               e = sb.pop_front();
               check("sel", W'(out_data), W'(e.sel));
               check("sorted", out_sorted, e.srt);
               check("latency", W'(cyc), W'(e.acc_cyc + N + (stall_cnt - e.acc_stall)));
            end
         end
         if (in_valid && in_ready) begin
            e.srt       = ref_sort(in_data);
            e.sel       = ref_sel(e.srt, in_mode);
            e.acc_cyc   = cyc;
            e.acc_stall = stall_cnt;
            sb.push_back(e);
         end
         run_len = out_valid ? run_len + 1 : 0;
         if (run_len > max_run) max_run = run_len;
         prev_stall  = out_valid && !out_ready;
         prev_data   = out_data;
         prev_sorted = out_sorted;
         if (prev_stall) stall_cnt++;
      end
      cyc++;
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] win, input logic [1:0] mode);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = win;
      in_mode  = mode;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_timeout: in_ready stayed 0, expected acceptance");
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic drain();
      int t;
      out_ready = 1'b1;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         step();
         t++;
      end
      check("drain_empty", W'(sb.size()), W'(0));
      repeat (2) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int  dir[N];
      int  s0;
      int  n0;
      bit  done_rand;

      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = 2'd0;
      out_ready = 1'b1;
      #1 rst = 1'b1;
      repeat (3) step();
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_out_data", W'(out_data), W'(0));
      check("rst_out_sorted", out_sorted, W'(0));
      check("rst_in_ready", W'(in_ready), W'(1));
      #2 rst = 1'b0;
      step();

      // Directed sort, modes, extremes, all-equal
      dir = '{9, 3, 7, 1, 8, 2, 6, 4, 5};
      send(pack(dir), 2'd0);
      send(pack(dir), 2'd1);
      send(pack(dir), 2'd2);
      dir = '{255, 0, 255, 0, 128, 0, 255, 0, 255};
      send(pack(dir), 2'd0);
      dir = '{42, 42, 42, 42, 42, 42, 42, 42, 42};
      send(pack(dir), 2'd0);
      send(pack(dir), 2'd3);
      drain();

      // Throughput: 20 back-to-back beats
      idle(3);
      max_run = 0;
      for (int i = 0; i < 20; i++) send(rand_win(), 2'(i % 4));
      drain();
      check("throughput_run", W'(max_run), W'(20));

      // Backpressure mid-stream
      s0 = stall_cnt;
      fork
         for (int i = 0; i < 12; i++) send(rand_win(), 2'($urandom_range(0, 3)));
         begin
            for (int t = 0; t < 100 && !out_valid; t++) step();
            step();
            step();
            out_ready = 1'b0;
            repeat (5) step();
            out_ready = 1'b1;
         end
      join
      drain();
      check("stall_cycles", W'(stall_cnt - s0), W'(5));

      // Bubbles 1,0,1,1,0,1
      n0 = n_out;
      send(rand_win(), 2'd0);
      idle(1);
      send(rand_win(), 2'd1);
      send(rand_win(), 2'd2);
      idle(1);
      send(rand_win(), 2'd0);
      drain();
      check("bubble_count", W'(n_out - n0), W'(4));

      // Reset with beats in flight
      idle(2);
      for (int i = 0; i < 4; i++) send(rand_win(), 2'd0);
      #1 rst = 1'b1;
      #1;
      check("arst_out_valid", W'(out_valid), W'(0));
      check("arst_out_data", W'(out_data), W'(0));
      check("arst_out_sorted", out_sorted, W'(0));
      check("arst_in_ready", W'(in_ready), W'(1));
      repeat (2) step();
      check("arst_hold_valid", W'(out_valid), W'(0));
      #2 rst = 1'b0;
      step();
      n0 = n_out;
      dir = '{2, 1, 3, 200, 17, 99, 0, 255, 64};
      send(pack(dir), 2'd0);
      drain();
      repeat (N + 2) step();
      check("post_rst_count", W'(n_out - n0), W'(1));

      // Random traffic with random backpressure and gaps
      done_rand = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               if ($urandom_range(0, 3) == 0) idle(1);
               send(rand_win(), 2'($urandom_range(0, 3)));
            end
            done_rand = 1'b1;
         end
         begin
            while (!done_rand) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      drain();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
